// File: rtl/eth_frame_detector_log_arbiter.sv
// Packet-level round-robin arbiter merging several AXI-Stream log channels onto
// one output; a grant is held from the first beat through the tlast beat.
module eth_frame_detector_log_arbiter #(
    parameter int  C_AXIS_LOG_WIDTH = 64,
    parameter int  C_NUM_INPUTS     = 2,
    localparam int C_DEST_WIDTH     = ($clog2(C_NUM_INPUTS) > 1) ? $clog2(C_NUM_INPUTS) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     enable,
    input  logic [C_NUM_INPUTS*C_AXIS_LOG_WIDTH-1:0] s_axis_log_tdata,
    input  logic [C_NUM_INPUTS-1:0]                  s_axis_log_tlast,
    input  logic [C_NUM_INPUTS-1:0]                  s_axis_log_tvalid,
    output logic [C_NUM_INPUTS-1:0]                  s_axis_log_tready,
    output logic [C_AXIS_LOG_WIDTH-1:0]              m_axis_log_tdata,
    output logic [C_DEST_WIDTH-1:0]                  m_axis_log_tdest,
    output logic                                     m_axis_log_tlast,
    output logic                                     m_axis_log_tvalid,
    input  logic                                     m_axis_log_tready,
    output logic                                     busy,
    output logic [31:0]                              pkt_count
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_FORWARD = 1'b1
    } state_t;

    localparam logic [C_DEST_WIDTH:0] NUM_INPUTS_W = (C_DEST_WIDTH+1)'(C_NUM_INPUTS);

    state_t                  state_q, state_d;
    logic [C_DEST_WIDTH-1:0] grant_q, grant_d;
    logic [C_DEST_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [31:0]             pkt_count_q, pkt_count_d;

    logic                    req_found;
    logic [C_DEST_WIDTH-1:0] req_idx;
    logic [C_DEST_WIDTH:0]   cand;
    logic                    end_of_pkt;

    // Search starts just after the previous winner so every requester is
    // served within C_NUM_INPUTS packets.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        req_found = 1'b0;
        req_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= C_NUM_INPUTS; k++) begin
            cand = {1'b0, last_grant_q} + (C_DEST_WIDTH+1)'(k);
            if (cand >= NUM_INPUTS_W) begin
                cand = cand - NUM_INPUTS_W;
            end
            if (!req_found && s_axis_log_tvalid[cand[C_DEST_WIDTH-1:0]]) begin
                req_found = 1'b1;
                req_idx   = cand[C_DEST_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        last_grant_d      = last_grant_q;
        pkt_count_d       = pkt_count_q;
        m_axis_log_tdata  = '0;
        m_axis_log_tlast  = 1'b0;
        m_axis_log_tvalid = 1'b0;
        m_axis_log_tdest  = '0;
        s_axis_log_tready = '0;
        busy              = 1'b0;
        end_of_pkt        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && req_found) begin
                    grant_d      = req_idx;
                    last_grant_d = req_idx;
                    state_d      = ST_FORWARD;
                end
            end
            ST_FORWARD: begin
                busy                       = 1'b1;
                m_axis_log_tdata           = s_axis_log_tdata[int'(grant_q)*C_AXIS_LOG_WIDTH +: C_AXIS_LOG_WIDTH];
                m_axis_log_tlast           = s_axis_log_tlast[grant_q];
                m_axis_log_tvalid          = s_axis_log_tvalid[grant_q];
                m_axis_log_tdest           = grant_q;
                s_axis_log_tready[grant_q] = m_axis_log_tready;
                end_of_pkt = s_axis_log_tvalid[grant_q] & m_axis_log_tready & s_axis_log_tlast[grant_q];
                if (end_of_pkt) begin
                    pkt_count_d = pkt_count_q + 32'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset is synchronous; last_grant starts at the top index so input 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= C_DEST_WIDTH'(C_NUM_INPUTS - 1);
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;

endmodule

// File: doc/eth_frame_detector_log_arbiter.md
Name: eth_frame_detector_log_arbiter

Overview:
- Packet-level round-robin arbiter that merges up to C_NUM_INPUTS AXI-Stream log channels onto one shared log output.
- Inputs are the per-direction frame detector log streams; the output feeds the shared log DMA/FIFO.
- A grant is held for the whole packet, from first beat to the tlast beat, so packets never interleave.
- Provides a global enable, a source tag on every output beat, and a forwarded-packet counter.

Parameters:
- C_AXIS_LOG_WIDTH, 64, data width of every log stream in bits; multiple of 8, at least 64.
- C_NUM_INPUTS, 2, number of requesting log streams; range 2..8.
- C_DEST_WIDTH, derived max(1, $clog2(C_NUM_INPUTS)), width of the source tag; not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  when low, no new grant is issued; a packet already granted completes
- s_axis_log_tdata  in  C_NUM_INPUTS*C_AXIS_LOG_WIDTH  flattened data; input i occupies slice [i*W +: W]
- s_axis_log_tlast  in  C_NUM_INPUTS  per-input tlast
- s_axis_log_tvalid  in  C_NUM_INPUTS  per-input tvalid
- s_axis_log_tready  out  C_NUM_INPUTS  per-input tready
- m_axis_log_tdata  out  C_AXIS_LOG_WIDTH  merged data
- m_axis_log_tdest  out  C_DEST_WIDTH  index of the input that owns the current beat
- m_axis_log_tlast  out  1  merged tlast
- m_axis_log_tvalid  out  1  merged tvalid
- m_axis_log_tready  in  1  downstream ready
- busy  out  1  high while a grant is held (ST_FORWARD)
- pkt_count  out  32  number of packets forwarded since reset; wraps modulo 2^32

Behaviour:
- Reset values:
  - state = ST_IDLE; grant = 0; last_grant = C_NUM_INPUTS-1, so input 0 has top priority after reset.
  - pkt_count = 0; busy = 0; all s_axis_log_tready = 0.
  - m_axis_log_tvalid = 0, m_axis_log_tlast = 0, m_axis_log_tdata = 0, m_axis_log_tdest = 0.
- States: ST_IDLE, ST_FORWARD.
- ST_IDLE:
  - All outputs are 0 (tvalid, tready, tdata, tlast, tdest).
  - If enable=1 and any s_tvalid is high, select the first valid input in the order last_grant+1, last_grant+2, …, last_grant (indices modulo C_NUM_INPUTS).
  - Register that index into grant and last_grant, then go to ST_FORWARD.
  - Arbitration uses only tvalid; tdata and tlast are not inspected.
- ST_FORWARD (combinational pass-through of the granted input):
  - m_tdata / m_tlast / m_tvalid = s_tdata / s_tlast / s_tvalid of input [grant].
  - m_tdest = grant.
  - s_tready[grant] = m_tready; every other s_tready = 0.
  - busy = 1.
- Packet end: on a handshake (m_tvalid & m_tready) with m_tlast=1:
  - pkt_count increments;
  - next state is ST_IDLE.
- Latency:
  - One cycle from a request in ST_IDLE to the first m_tvalid.
  - One idle cycle between consecutive packets.
  - Throughput within a packet is one beat per cycle.
- enable:
  - Sampled only in ST_IDLE.
  - Dropping enable while in ST_FORWARD has no effect until tlast is accepted.
- Input tvalid deassertion mid-packet: the grant is held and m_tvalid follows the granted input's tvalid. There is no timeout.
- Non-granted inputs stall with tready=0; their data is not consumed or dropped.
- Single-beat packet (tlast on the first beat): the arbiter enters ST_FORWARD for one beat, then returns to ST_IDLE.
- Simultaneous requests: strict round-robin as above. Each input is guaranteed service within C_NUM_INPUTS packets.
- Reset asserted mid-packet: the arbiter returns to reset values on the next edge and the partial packet is truncated downstream. Upstream blocks share the same reset.
- pkt_count wrap: 0xFFFFFFFF + 1 → 0.

Test Plan:
- Single input: input 0 sends 3 beats (tlast on beat 3), m_tready=1 → m_tvalid one cycle after s_tvalid; 3 beats out with tdest=0 and tlast on beat 3; pkt_count=1.
- Both inputs request on the same cycle right after reset, 2-beat packets each → input 0 first, then one idle cycle, then input 1; tdest 0,0,1,1; pkt_count=2.
- Fairness: input 0 continuously requests, input 1 requests one packet → grant order 0,1,0,0…; input 1 waits at most one packet.
- Backpressure: m_tready toggled 1,0,1,0 during a 4-beat packet on input 1 → s_tready[1] mirrors m_tready; data order intact; s_tready[0]=0 throughout.
- Enable: enable=0 with both inputs valid → no tvalid out, busy=0. Enable deasserted mid-packet → the current packet completes and no further grant is issued until enable=1.
- Reset mid-packet on beat 2 of 4 → next cycle m_tvalid=0, all tready=0, pkt_count=0, and input 0 wins the next arbitration.
